lane_phase_scheduler: RTL and testbench
=======================================

Name: lane_phase_scheduler

Overview:
- Sequences the 4-way intersection: chooses which approach (N/E/S/W, two lanes each) gets green, and times yellow and all-red clearance.
- Serves latched pedestrian requests with an all-way walk phase.
- Pre-empts for an emergency vehicle in a given lane.
- Sits inside Breadboard, between the stimulus signals/lane counts and the traffic/walking light outputs.

Parameters:
- CNT_W, 8, width of each lane car count
- MIN_GREEN, 4, minimum green cycles before a demand-driven change
- MAX_GREEN, 12, maximum green cycles (day) when another phase has demand; doubled at night
- YELLOW, 2, yellow cycles
- ALL_RED, 1, all-red clearance cycles
- PED_WALK, 5, walk phase cycles

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- timeSignal  in  1  0=day, 1=night
- pedSignal  in  1  pedestrian request; a 1-cycle pulse is sufficient (latched)
- emgSignal  in  1  emergency active (level)
- emgLane  in  8  one-hot emergency lane
- laneCounts  in  8*CNT_W  packed {w1,w2,s1,s2,e1,e2,n1,n2}; lane i at [CNT_W*i +: CNT_W]
- trafficLightOutput  out  8  per-lane green
- yellowLightOutput  out  8  per-lane yellow
- walkingLightOutput  out  8  per-crossing walk
- trafficMode  out  2  00 day, 01 night, 10 ped, 11 emergency
- phase  out  2  current/last vehicle phase: 0 N, 1 E, 2 S, 3 W

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high. Ports are clk and rst.
- Lane map: lanes 0..7 = n2,n1,e2,e1,s2,s1,w2,w1. Phase p owns lanes 2p and 2p+1.
- Phase demand = sum of its two counts, CNT_W+1 bits, no overflow.
- States: ALLRED, GREEN, YELLOW, PED_WALK, EMG_HOLD.
  - A cycle timer clears on every state change.
  - All outputs are registered and decoded from the next-state, so lights change on the same edge the state does.
- Reset (async):
  - state=ALLRED, phase=3, timer=0, pedPending=0, emgPhase cleared.
  - All light outputs 0, trafficMode=00.
- ALLRED, after ALL_RED cycles, in priority order:
  - emergency pending -> GREEN on the emergency phase;
  - else pedPending -> PED_WALK;
  - else arbitrate:
    - pick the phase with the largest demand;
    - ties go round-robin starting at phase+1;
    - all demands zero: day -> phase+1; night -> keep phase.
- GREEN:
  - Both lanes of the phase are green.
  - After timer >= MIN_GREEN: go to YELLOW if any other phase has demand and either the own demand is 0 or timer >= max green (MAX_GREEN day, 2*MAX_GREEN night). Also go to YELLOW if pedPending.
  - With no competing demand and no pedPending, green rests indefinitely.
- YELLOW: both phase lanes yellow for YELLOW cycles, then ALLRED.
- PED_WALK:
  - walkingLightOutput=8'hFF, all vehicle lights 0, trafficMode=10.
  - After PED_WALK cycles -> ALLRED and pedPending cleared.
- Pedestrian latch: pedSignal sets pedPending in any state; it is cleared only when PED_WALK completes. Multiple pulses are served once.
- Emergency:
  - On emgSignal=1 with emgLane!=0, target phase = phase of the lowest set bit. emgLane==0 is ignored.
  - In GREEN on the target phase -> EMG_HOLD directly, green kept.
  - In GREEN on another phase -> YELLOW immediately, MIN_GREEN ignored.
  - In PED_WALK -> ALLRED immediately; walk aborted, pedPending kept.
  - YELLOW/ALLRED complete normally, then GREEN on the target, then EMG_HOLD.
  - EMG_HOLD: target green, trafficMode=11 from the first pre-empt cycle until the hold ends; on emgSignal=0 -> YELLOW.
  - A lane change during EMG_HOLD re-targets through YELLOW.
- trafficMode outside ped/emergency is {1'b0,timeSignal}, registered.

Optional Feature:
- Macro: SCHED_NIGHT_FLASH_EN.
- Defined: a night ALLRED arbitration with all demands zero and no pending ped/emergency enters a FLASH state.
  - yellowLightOutput toggles 8'hFF/8'h00 every cycle, starting at FF.
  - Any demand, ped or emergency -> ALLRED, then the normal path.
- Undefined: FLASH does not exist; night rests green on the current phase.

Decomposition:
- Package traffic_sched_pkg: state enum, phase and mode codes, lane index constants, phase-to-lane-mask function.
- One sub-module demand_arbiter (combinational): per-phase sums, max-with-round-robin tie-break, any-other-demand flag.

Test Plan:
- Reset, n1=8'h80, rest 0, day -> after 1 ALLRED cycle trafficLightOutput=8'h03, phase=0, held 30 cycles.
- n1=8'h10, e1=8'h40, from N green -> green 12 cycles, yellow 8'h03 for 2, all-red 1, then green 8'h0C, phase=1.
- Cycle 2 of N green, emgSignal=1, emgLane=8'h08 -> yellow next cycle, 2 yellow, 1 all-red, green 8'h0C, trafficMode=11; drop emgSignal -> yellow 8'h0C.
- 1-cycle pedSignal during N green with e1 demand -> after MIN_GREEN, yellow, all-red: walkingLightOutput=8'hFF, all greens 0, mode 10 for 5 cycles.
- E green ends, N and S demands both 5 -> S chosen, trafficLightOutput=8'h30.
- rst asserted mid EMG_HOLD -> all outputs 0 in the same cycle (async), pedPending cleared; after release, ALLRED then phase 0.

Source files
------------

// File: rtl/traffic_sched_pkg.sv
// Shared scheduler types: state encoding, mode/phase codes, lane indices and
// the phase-to-lane mask helper used by the scheduler and its arbiter.
package traffic_sched_pkg;

    localparam int NUM_LANES  = 8;
    localparam int NUM_PHASES = 4;

    // Lane 0 is n2, lane 7 is w1; phase p owns lanes 2p and 2p+1.
    localparam int LANE_N2 = 0;
    localparam int LANE_W1 = 7;

    localparam logic [1:0] PHASE_N = 2'd0;
    localparam logic [1:0] PHASE_W = 2'd3;

    localparam logic [1:0] MODE_DAY   = 2'b00;
    localparam logic [1:0] MODE_NIGHT = 2'b01;
    localparam logic [1:0] MODE_PED   = 2'b10;
    localparam logic [1:0] MODE_EMG   = 2'b11;

    typedef enum logic [2:0] {
        ST_ALLRED,
        ST_GREEN,
        ST_YELLOW,
        ST_PED_WALK,
        ST_EMG_HOLD,
        ST_FLASH
    } schedState_t;

    function automatic logic [NUM_LANES-1:0] phaseMask(input logic [1:0] p);
        return 8'b0000_0011 << {p, 1'b0};
    endfunction

endpackage

// File: rtl/demand_arbiter.sv
// Combinational demand arbiter: per-phase car sums, largest-demand pick with
// round-robin tie-break starting after the current phase, and demand flags.
module demand_arbiter
    import traffic_sched_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic [NUM_LANES*CNT_W-1:0] laneCounts,
    input  logic [1:0]                 curPhase,
    output logic [1:0]                 bestPhase,
    output logic                       anyDemand,
    output logic                       otherDemand,
    output logic                       ownDemand
);

    logic [CNT_W:0] demand [NUM_PHASES];
    logic [1:0]     cand;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PHASES; gi++) begin : g_sum
            assign demand[gi] = {1'b0, laneCounts[CNT_W*(2*gi) +: CNT_W]}
                              + {1'b0, laneCounts[CNT_W*(2*gi+1) +: CNT_W]};
        end
    endgenerate

    // Strict compare keeps the earliest phase in round-robin order on ties.
    always_comb begin
        bestPhase   = curPhase + 2'd1;
        cand        = bestPhase;
        anyDemand   = 1'b0;
        otherDemand = 1'b0;
        for (int k = 2; k <= NUM_PHASES; k++) begin
            cand = curPhase + 2'(k);
            if (demand[cand] > demand[bestPhase]) begin
                bestPhase = cand;
            end
        end
        for (int p = 0; p < NUM_PHASES; p++) begin
            if (demand[p] != '0) begin
                anyDemand = 1'b1;
                if (2'(p) != curPhase) begin
                    otherDemand = 1'b1;
                end
            end
        end
    end

    assign ownDemand = (demand[curPhase] != '0);

endmodule

// File: rtl/lane_phase_scheduler.sv
// Four-way intersection phase sequencer with pedestrian walk and emergency
// pre-emption. Optional night flashing-yellow state: SCHED_NIGHT_FLASH_EN.
module lane_phase_scheduler
    import traffic_sched_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 12,
    parameter int YELLOW    = 2,
    parameter int ALL_RED   = 1,
    parameter int PED_WALK  = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       timeSignal,
    input  logic                       pedSignal,
    input  logic                       emgSignal,
    input  logic [NUM_LANES-1:0]       emgLane,
    input  logic [NUM_LANES*CNT_W-1:0] laneCounts,
    output logic [NUM_LANES-1:0]       trafficLightOutput,
    output logic [NUM_LANES-1:0]       yellowLightOutput,
    output logic [NUM_LANES-1:0]       walkingLightOutput,
    output logic [1:0]                 trafficMode,
    output logic [1:0]                 phase
);

    localparam int TIMER_W = 8;

    schedState_t          stateReg, stateNext;
    logic [TIMER_W-1:0]   timerReg, greenLimit;
    logic [1:0]           phaseNext, emgPhaseReg, emgTarget, bestPhase;
    logic                 pedPendingReg, pedPendingNext, pedClear, emgActive;
    logic                 anyDemand, otherDemand, ownDemand;
    logic [NUM_LANES-1:0] trafficNext, yellowNext, walkNext;
    logic [1:0]           modeNext;

    demand_arbiter #(.CNT_W(CNT_W)) arbiter (
        .laneCounts  (laneCounts),
        .curPhase    (phase),
        .bestPhase   (bestPhase),
        .anyDemand   (anyDemand),
        .otherDemand (otherDemand),
        .ownDemand   (ownDemand)
    );

    // Lowest set lane bit wins when several emergency lanes are flagged.
    always_comb begin
        emgTarget = PHASE_N;
        for (int i = LANE_W1; i >= LANE_N2; i--) begin
            if (emgLane[i]) begin
                emgTarget = 2'(i / 2);
            end
        end
    end

    assign emgActive  = emgSignal && (emgLane != '0);
    assign greenLimit = timeSignal ? TIMER_W'(2*MAX_GREEN - 1) : TIMER_W'(MAX_GREEN - 1);

    // Timer holds cycles already spent in the state, so "done" is N-1.
    always_comb begin
        stateNext = stateReg;
        phaseNext = phase;
        pedClear  = 1'b0;
        case (stateReg)
            ST_ALLRED: begin
                if (timerReg >= TIMER_W'(ALL_RED - 1)) begin
                    if (emgActive) begin
                        stateNext = ST_GREEN;
                        phaseNext = emgTarget;
                    end else if (pedPendingReg) begin
                        stateNext = ST_PED_WALK;
                    end else if (!anyDemand) begin
`ifdef SCHED_NIGHT_FLASH_EN
                        if (timeSignal) begin
                            stateNext = ST_FLASH;
                        end else
`endif
                        begin
                            stateNext = ST_GREEN;
                            phaseNext = timeSignal ? phase : phase + 2'd1;
                        end
                    end else begin
                        stateNext = ST_GREEN;
                        phaseNext = bestPhase;
                    end
                end
            end
            ST_GREEN: begin
                if (emgActive) begin
                    stateNext = (emgTarget == phase) ? ST_EMG_HOLD : ST_YELLOW;
                end else if (timerReg >= TIMER_W'(MIN_GREEN - 1) &&
                             (pedPendingReg ||
                              (otherDemand && (!ownDemand || timerReg >= greenLimit)))) begin
                    stateNext = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (timerReg >= TIMER_W'(YELLOW - 1)) begin
                    stateNext = ST_ALLRED;
                end
            end
            ST_PED_WALK: begin
                if (emgActive) begin
                    stateNext = ST_ALLRED;
                end else if (timerReg >= TIMER_W'(PED_WALK - 1)) begin
                    stateNext = ST_ALLRED;
                    pedClear  = 1'b1;
                end
            end
            ST_EMG_HOLD: begin
                if (!emgActive || emgTarget != emgPhaseReg) begin
                    stateNext = ST_YELLOW;
                end
            end
`ifdef SCHED_NIGHT_FLASH_EN
            ST_FLASH: begin
                if (anyDemand || pedPendingReg || emgActive) begin
                    stateNext = ST_ALLRED;
                end
            end
`endif
            default: stateNext = ST_ALLRED;
        endcase
    end

    assign pedPendingNext = pedClear ? 1'b0 : (pedPendingReg | pedSignal);

    always_comb begin
        trafficNext = '0;
        yellowNext  = '0;
        walkNext    = '0;
        case (stateNext)
            ST_GREEN, ST_EMG_HOLD: trafficNext = phaseMask(phaseNext);
            ST_YELLOW:             yellowNext  = phaseMask(phaseNext);
            ST_PED_WALK:           walkNext    = '1;
`ifdef SCHED_NIGHT_FLASH_EN
            ST_FLASH:              yellowNext  = (stateReg == ST_FLASH) ? ~yellowLightOutput : '1;
`endif
            default: ;
        endcase
        modeNext = emgActive                  ? MODE_EMG :
                   (stateNext == ST_PED_WALK) ? MODE_PED :
                   timeSignal                 ? MODE_NIGHT : MODE_DAY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg           <= ST_ALLRED;
            phase              <= PHASE_W;
            timerReg           <= '0;
            pedPendingReg      <= 1'b0;
            emgPhaseReg        <= PHASE_N;
            trafficLightOutput <= '0;
            yellowLightOutput  <= '0;
            walkingLightOutput <= '0;
            trafficMode        <= MODE_DAY;
        end else begin
            stateReg      <= stateNext;
            phase         <= phaseNext;
            pedPendingReg <= pedPendingNext;
            if (stateNext != stateReg) begin
                timerReg <= '0;
            end else if (timerReg != '1) begin
                timerReg <= timerReg + 1'b1;
            end
            if (stateNext == ST_EMG_HOLD) begin
                emgPhaseReg <= phaseNext;
            end
            trafficLightOutput <= trafficNext;
            yellowLightOutput  <= yellowNext;
            walkingLightOutput <= walkNext;
            trafficMode        <= modeNext;
        end
    end

endmodule

// File: tb/tb_lane_phase_scheduler.sv
// Self-checking bench for lane_phase_scheduler: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_lane_phase_scheduler;

    localparam int CNT_W     = 8;
    localparam int MIN_GREEN = 4;
    localparam int MAX_GREEN = 12;
    localparam int YELLOW    = 2;
    localparam int ALL_RED   = 1;
    localparam int PED_WALK  = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        timeSignal = 1'b0;
    logic        pedSignal = 1'b0;
    logic        emgSignal = 1'b0;
    logic [7:0]  emgLane = 8'h00;
    logic [63:0] laneCounts = 64'h0;
    logic [7:0]  trafficLightOutput, yellowLightOutput, walkingLightOutput;
    logic [1:0]  trafficMode, phase;

    int checks = 0;
    int failures = 0;

    lane_phase_scheduler #(
        .CNT_W(CNT_W), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
        .YELLOW(YELLOW), .ALL_RED(ALL_RED), .PED_WALK(PED_WALK)
    ) dut (
        .clk(clk), .rst(rst), .timeSignal(timeSignal), .pedSignal(pedSignal),
        .emgSignal(emgSignal), .emgLane(emgLane), .laneCounts(laneCounts),
        .trafficLightOutput(trafficLightOutput), .yellowLightOutput(yellowLightOutput),
        .walkingLightOutput(walkingLightOutput), .trafficMode(trafficMode), .phase(phase)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Behavioural reference: counts cycles spent in each light state.
    localparam int M_ALLRED = 0, M_GREEN = 1, M_YELLOW = 2, M_WALK = 3, M_HOLD = 4;
    int         mState, mCycles, mPhase;
    bit         mPed;
    logic [7:0] expTraffic, expYellow, expWalk;
    logic [1:0] expMode;

    function automatic void modelReset();
        mState = M_ALLRED; mCycles = 0; mPhase = 3; mPed = 0;
        expTraffic = 0; expYellow = 0; expWalk = 0; expMode = 0;
    endfunction

    function automatic void modelStep();
        int d[4];
        int nxt, nxtPhase, target, limit, maxD, total;
        bit emg, other, clearPed, found;
        total = 0; maxD = 0; other = 0;
        for (int p = 0; p < 4; p++) begin
            d[p] = int'(laneCounts[16*p +: 8]) + int'(laneCounts[16*p+8 +: 8]);
            total += d[p];
            if (d[p] > maxD) maxD = d[p];
            if (p != mPhase && d[p] > 0) other = 1;
        end
        emg = emgSignal && (emgLane != 0);
        target = 0;
        for (int i = 7; i >= 0; i--) if (emgLane[i]) target = i / 2;
        limit = timeSignal ? 2*MAX_GREEN : MAX_GREEN;
        mCycles++;
        nxt = mState; nxtPhase = mPhase; clearPed = 0;
        case (mState)
            M_ALLRED: if (mCycles >= ALL_RED) begin
                if (emg) begin nxt = M_GREEN; nxtPhase = target; end
                else if (mPed) nxt = M_WALK;
                else begin
                    nxt = M_GREEN;
                    if (total == 0) nxtPhase = timeSignal ? mPhase : (mPhase + 1) % 4;
                    else begin
                        found = 0;
                        for (int k = 1; k <= 4; k++)
                            if (!found && d[(mPhase + k) % 4] == maxD) begin
                                nxtPhase = (mPhase + k) % 4; found = 1;
                            end
                    end
                end
            end
            M_GREEN: begin
                if (emg) nxt = (target == mPhase) ? M_HOLD : M_YELLOW;
                else if (mCycles >= MIN_GREEN &&
                         (mPed || (other && (d[mPhase] == 0 || mCycles >= limit)))) nxt = M_YELLOW;
            end
            M_YELLOW: if (mCycles >= YELLOW) nxt = M_ALLRED;
            M_WALK: begin
                if (emg) nxt = M_ALLRED;
                else if (mCycles >= PED_WALK) begin nxt = M_ALLRED; clearPed = 1; end
            end
            M_HOLD: if (!emg || target != mPhase) nxt = M_YELLOW;
            default: nxt = M_ALLRED;
        endcase
        mPed = clearPed ? 1'b0 : (mPed | pedSignal);
        if (nxt != mState) mCycles = 0;
        mState = nxt; mPhase = nxtPhase;
        expTraffic = (mState == M_GREEN || mState == M_HOLD) ? 8'(3 << (2*mPhase)) : 8'h00;
        expYellow  = (mState == M_YELLOW) ? 8'(3 << (2*mPhase)) : 8'h00;
        expWalk    = (mState == M_WALK) ? 8'hFF : 8'h00;
        expMode    = emg ? 2'd3 : (mState == M_WALK) ? 2'd2 : {1'b0, timeSignal};
    endfunction

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic setLane(input int lane, input int val);
        laneCounts[CNT_W*lane +: CNT_W] = CNT_W'(val);
    endtask

    task automatic clearInputs();
        laneCounts = 0; pedSignal = 0; emgSignal = 0; emgLane = 0; timeSignal = 0;
    endtask

    task automatic doReset();
        @(negedge clk); rst = 1; modelReset();
        @(negedge clk); rst = 0;
    endtask

    task automatic test_reset();
        int n;
        clearInputs(); setLane(1, 8'h80);
        @(negedge clk); rst = 1; modelReset(); #1;
        checks++;
        if (trafficLightOutput !== 0 || yellowLightOutput !== 0 || walkingLightOutput !== 0 || trafficMode !== 0) begin
            failures++;
            $display("FAIL reset_outputs got t=%h y=%h w=%h m=%0d want all 0", trafficLightOutput, yellowLightOutput, walkingLightOutput, trafficMode);
        end
        checks++;
        if (phase !== 2'd3) begin failures++; $display("FAIL reset_phase got=%0d want=3", phase); end
        @(negedge clk); rst = 0;
        tick();
        checks++;
        if (trafficLightOutput !== 8'h03 || phase !== 2'd0) begin
            failures++; $display("FAIL first_green got t=%h p=%0d want t=03 p=0", trafficLightOutput, phase);
        end
        n = 0;
        repeat (30) begin tick(); if (trafficLightOutput == 8'h03 && yellowLightOutput == 0) n++; end
        checks++;
        if (n !== 30) begin failures++; $display("FAIL green_rest got=%0d want=30", n); end
        $display("test_reset done");
    endtask

    task automatic test_max_green();
        int n;
        clearInputs(); setLane(1, 8'h10); doReset(); tick();
        setLane(3, 8'h40);
        n = 0; while (trafficLightOutput == 8'h03 && n < 100) begin n++; tick(); end
        checks++; if (n !== MAX_GREEN) begin failures++; $display("FAIL max_green_len got=%0d want=%0d", n, MAX_GREEN); end
        n = 0; while (yellowLightOutput == 8'h03 && n < 20) begin n++; tick(); end
        checks++; if (n !== YELLOW) begin failures++; $display("FAIL yellow_len got=%0d want=%0d", n, YELLOW); end
        n = 0; while (trafficLightOutput == 0 && yellowLightOutput == 0 && n < 20) begin n++; tick(); end
        checks++; if (n !== ALL_RED) begin failures++; $display("FAIL allred_len got=%0d want=%0d", n, ALL_RED); end
        checks++;
        if (trafficLightOutput !== 8'h0C || phase !== 2'd1) begin
            failures++; $display("FAIL east_green got t=%h p=%0d want t=0c p=1", trafficLightOutput, phase);
        end
        $display("test_max_green done");
    endtask

    task automatic test_emergency();
        int n;
        clearInputs(); setLane(1, 8'h80); doReset(); tick(); tick();
        emgSignal = 1; emgLane = 8'h08;
        n = 0; while (yellowLightOutput == 8'h00 && n < 5) begin n++; tick(); end
        checks++;
        if (n !== 1 || trafficMode !== 2'd3 || yellowLightOutput !== 8'h03) begin
            failures++; $display("FAIL emg_preempt got lat=%0d y=%h m=%0d want lat=1 y=03 m=3", n, yellowLightOutput, trafficMode);
        end
        n = 0; while (yellowLightOutput == 8'h03 && n < 20) begin n++; tick(); end
        checks++; if (n !== YELLOW) begin failures++; $display("FAIL emg_yellow_len got=%0d want=%0d", n, YELLOW); end
        n = 0; while (trafficLightOutput == 0 && yellowLightOutput == 0 && n < 20) begin n++; tick(); end
        checks++; if (n !== ALL_RED) begin failures++; $display("FAIL emg_allred_len got=%0d want=%0d", n, ALL_RED); end
        checks++;
        if (trafficLightOutput !== 8'h0C || phase !== 2'd1 || trafficMode !== 2'd3) begin
            failures++; $display("FAIL emg_green got t=%h p=%0d m=%0d want t=0c p=1 m=3", trafficLightOutput, phase, trafficMode);
        end
        repeat (5) tick();
        checks++;
        if (trafficLightOutput !== 8'h0C || trafficMode !== 2'd3) begin
            failures++; $display("FAIL emg_hold got t=%h m=%0d want t=0c m=3", trafficLightOutput, trafficMode);
        end
        emgSignal = 0; tick();
        checks++;
        if (yellowLightOutput !== 8'h0C || trafficLightOutput !== 0 || trafficMode !== 2'd0) begin
            failures++; $display("FAIL emg_release got y=%h t=%h m=%0d want y=0c t=00 m=0", yellowLightOutput, trafficLightOutput, trafficMode);
        end
        $display("test_emergency done");
    endtask

    task automatic test_ped();
        int n;
        clearInputs(); setLane(1, 8'h80); doReset(); tick();
        setLane(3, 8'h01); pedSignal = 1;
        n = 0; while (trafficLightOutput == 8'h03 && n < 100) begin n++; tick(); pedSignal = 0; end
        checks++; if (n !== MIN_GREEN) begin failures++; $display("FAIL ped_green_len got=%0d want=%0d", n, MIN_GREEN); end
        n = 0; while (walkingLightOutput != 8'hFF && n < 10) begin n++; tick(); end
        checks++; if (n !== YELLOW + ALL_RED) begin failures++; $display("FAIL ped_to_walk got=%0d want=%0d", n, YELLOW + ALL_RED); end
        n = 0;
        while (walkingLightOutput == 8'hFF && trafficLightOutput == 0 && yellowLightOutput == 0 && trafficMode == 2'd2 && n < 20) begin
            n++; tick();
        end
        checks++; if (n !== PED_WALK) begin failures++; $display("FAIL walk_len got=%0d want=%0d", n, PED_WALK); end
        tick();
        checks++;
        if (trafficLightOutput !== 8'h03 || walkingLightOutput !== 0) begin
            failures++; $display("FAIL ped_served_once got t=%h w=%h want t=03 w=00", trafficLightOutput, walkingLightOutput);
        end
        $display("test_ped done");
    endtask

    task automatic test_rr_tie();
        int n;
        clearInputs(); setLane(3, 8'h10); doReset(); tick();
        checks++;
        if (trafficLightOutput !== 8'h0C || phase !== 2'd1) begin
            failures++; $display("FAIL rr_setup got t=%h p=%0d want t=0c p=1", trafficLightOutput, phase);
        end
        setLane(3, 0); setLane(1, 5); setLane(5, 5);
        n = 0;
        while ((trafficLightOutput == 8'h0C || trafficLightOutput == 8'h00) && n < 50) begin n++; tick(); end
        checks++;
        if (trafficLightOutput !== 8'h30 || phase !== 2'd2) begin
            failures++; $display("FAIL rr_tie got t=%h p=%0d want t=30 p=2", trafficLightOutput, phase);
        end
        $display("test_rr_tie done");
    endtask

    task automatic test_async_reset();
        clearInputs(); setLane(1, 8'h80); doReset(); tick();
        emgSignal = 1; emgLane = 8'h01; tick();
        pedSignal = 1; tick(); pedSignal = 0; tick();
        checks++;
        if (trafficLightOutput !== 8'h03 || trafficMode !== 2'd3) begin
            failures++; $display("FAIL hold_before_reset got t=%h m=%0d want t=03 m=3", trafficLightOutput, trafficMode);
        end
        #2 rst = 1; modelReset(); #1;
        checks++;
        if (trafficLightOutput !== 0 || yellowLightOutput !== 0 || walkingLightOutput !== 0 || trafficMode !== 0 || phase !== 2'd3) begin
            failures++;
            $display("FAIL async_reset got t=%h y=%h w=%h m=%0d p=%0d want 0/0/0/0/3", trafficLightOutput, yellowLightOutput, walkingLightOutput, trafficMode, phase);
        end
        clearInputs();
        @(negedge clk); rst = 0;
        tick();
        checks++;
        if (trafficLightOutput !== 8'h03 || phase !== 2'd0 || walkingLightOutput !== 0) begin
            failures++; $display("FAIL post_reset got t=%h p=%0d w=%h want t=03 p=0 w=00", trafficLightOutput, phase, walkingLightOutput);
        end
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        clearInputs(); doReset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 19) == 0) begin
                for (int l = 0; l < 8; l++) begin
                    if ($urandom_range(0, 2) == 0) setLane(l, 0);
                    else if ($urandom_range(0, 3) == 0) setLane(l, $urandom_range(0, 255));
                    else setLane(l, $urandom_range(1, 4));
                end
            end
            if ($urandom_range(0, 99) == 0) timeSignal = ~timeSignal;
            pedSignal = ($urandom_range(0, 49) == 0);
            if (emgSignal) begin
                if ($urandom_range(0, 14) == 0) emgSignal = 0;
                else if ($urandom_range(0, 39) == 0) emgLane = 8'(1 << $urandom_range(0, 7));
            end else if ($urandom_range(0, 79) == 0) begin
                emgSignal = 1;
                if ($urandom_range(0, 9) == 0) emgLane = 8'h00;
                else if ($urandom_range(0, 3) == 0) emgLane = 8'($urandom) | 8'h80;
                else emgLane = 8'(1 << $urandom_range(0, 7));
            end
            tick();
            checks++;
            if (trafficLightOutput !== expTraffic || yellowLightOutput !== expYellow ||
                walkingLightOutput !== expWalk || trafficMode !== expMode || phase !== 2'(mPhase)) begin
                failures++; errs++;
                if (errs <= 20)
                    $display("FAIL random cyc=%0d got t=%h y=%h w=%h m=%0d p=%0d want t=%h y=%h w=%h m=%0d p=%0d",
                             cyc, trafficLightOutput, yellowLightOutput, walkingLightOutput, trafficMode, phase,
                             expTraffic, expYellow, expWalk, expMode, mPhase);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        modelReset();
        test_reset();
        test_max_green();
        test_emergency();
        test_ped();
        test_rr_tie();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
